// File: rtl/obi_arbiter_pkg.sv
// Shared definitions for the OBI round-robin arbiter: default bus widths,
// index-width helper and the arbiter state encoding.
package obi_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 32'd32;
    localparam int unsigned DEF_DATA_W = 32'd32;
    localparam int unsigned DEF_ID_W   = 32'd1;

    // Arbiter selection state: IDLE re-arbitrates every cycle, HOLD keeps
    // an ungranted request stable until the subordinate accepts it.
    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

    // Width of a manager index; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        int unsigned w;
        if (n > 32'd1) begin
            w = int'($clog2(n));
        end else begin
            w = 32'd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/obi_arbiter_if.sv
// OBI bus bundle for the arbiter: NUM_MGR packed manager ports on one side,
// a single subordinate port on the other.
// slave  : the arbiter's view (serves the managers, drives the subordinate)
// master : the environment's view (managers plus subordinate model)
interface obi_arbiter_if
    import obi_arb_pkg::*;
#(
    parameter int unsigned NUM_MGR = 32'd2,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned ID_W    = DEF_ID_W
) ();

    localparam int unsigned BE_W = DATA_W / 32'd8;

    // manager side
    logic [NUM_MGR-1:0]        m_obi_req;
    logic [NUM_MGR-1:0]        m_obi_gnt;
    logic [NUM_MGR*ADDR_W-1:0] m_obi_addr;
    logic [NUM_MGR-1:0]        m_obi_we;
    logic [NUM_MGR*BE_W-1:0]   m_obi_be;
    logic [NUM_MGR*DATA_W-1:0] m_obi_wdata;
    logic [NUM_MGR*ID_W-1:0]   m_obi_aid;
    logic [NUM_MGR-1:0]        m_obi_rvalid;
    logic [NUM_MGR-1:0]        m_obi_rready;
    logic [DATA_W-1:0]         m_obi_rdata;
    logic                      m_obi_err;
    logic [ID_W-1:0]           m_obi_rid;

    // subordinate side
    logic                      s_obi_req;
    logic                      s_obi_gnt;
    logic [ADDR_W-1:0]         s_obi_addr;
    logic                      s_obi_we;
    logic [BE_W-1:0]           s_obi_be;
    logic [DATA_W-1:0]         s_obi_wdata;
    logic [ID_W-1:0]           s_obi_aid;
    logic                      s_obi_rvalid;
    logic                      s_obi_rready;
    logic [DATA_W-1:0]         s_obi_rdata;
    logic                      s_obi_err;
    logic [ID_W-1:0]           s_obi_rid;

    modport slave (
        input  m_obi_req, m_obi_addr, m_obi_we, m_obi_be, m_obi_wdata, m_obi_aid, m_obi_rready,
        output m_obi_gnt, m_obi_rvalid, m_obi_rdata, m_obi_err, m_obi_rid,
        output s_obi_req, s_obi_addr, s_obi_we, s_obi_be, s_obi_wdata, s_obi_aid, s_obi_rready,
        input  s_obi_gnt, s_obi_rvalid, s_obi_rdata, s_obi_err, s_obi_rid
    );

    modport master (
        output m_obi_req, m_obi_addr, m_obi_we, m_obi_be, m_obi_wdata, m_obi_aid, m_obi_rready,
        input  m_obi_gnt, m_obi_rvalid, m_obi_rdata, m_obi_err, m_obi_rid,
        input  s_obi_req, s_obi_addr, s_obi_we, s_obi_be, s_obi_wdata, s_obi_aid, s_obi_rready,
        output s_obi_gnt, s_obi_rvalid, s_obi_rdata, s_obi_err, s_obi_rid
    );

endinterface

// File: rtl/obi_arbiter_idx_fifo.sv
// FIFO of granted manager indices. Pointers carry one extra wrap bit so
// full and empty are distinguishable when the index bits are equal.
module obi_arb_idx_fifo #(
    parameter int unsigned DEPTH = 32'd4,
    parameter int unsigned W     = 32'd1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             din_i,
    output logic [W-1:0]             head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW:0]  wptr_q;
    logic [PW:0]  rptr_q;
    logic [W-1:0] mem_q [DEPTH];

    assign head_o  = mem_q[rptr_q[PW-1:0]];
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    assign count_o = wptr_q - rptr_q;

    // Pointer and storage update; a full FIFO ignores push, an empty one ignores pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_i && !full_o) begin
                mem_q[wptr_q[PW-1:0]] <= din_i;
                wptr_q                <= wptr_q + {{PW{1'b0}}, 1'b1};
            end
            if (pop_i && !empty_o) begin
                rptr_q <= rptr_q + {{PW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/obi_arbiter.sv
// Round-robin arbiter sharing one OBI subordinate among NUM_MGR managers.
// Address phases are forwarded combinationally; the index of every granted
// manager is queued so in-order responses can be routed back.
module obi_arbiter
    import obi_arb_pkg::*;
#(
    parameter int unsigned NUM_MGR = 32'd2,
    parameter int unsigned MAX_OUT = 32'd4,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned ID_W    = DEF_ID_W
) (
    input  logic          clk,
    input  logic          rst_n,
    obi_arbiter_if.slave  bus,
    output logic          resp_orphan
);

    localparam int unsigned IDX_W = idx_width(NUM_MGR);
    localparam int unsigned BE_W  = DATA_W / 32'd8;
    localparam int unsigned CNT_W = $clog2(MAX_OUT) + 32'd1;

    arb_state_e         state_q;
    logic [IDX_W-1:0]   hold_idx_q;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic               resp_orphan_q;

    logic [IDX_W-1:0]   rr_pick_s;
    logic [IDX_W-1:0]   sel_s;
    logic               s_req_s;
    logic               addr_hs_s;
    logic               fifo_pop_s;
    logic [IDX_W-1:0]   fifo_head_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [CNT_W-1:0]   unused_fifo_count_s;
    logic [NUM_MGR-1:0] gnt_s;
    logic [NUM_MGR-1:0] rvalid_s;

    // (base + off) mod NUM_MGR, for off < NUM_MGR
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NUM_MGR) begin
            sum = sum - NUM_MGR;
        end else begin
            sum = sum;
        end
        return sum[IDX_W-1:0];
    endfunction

    // Round-robin search: first requester at or after rr_ptr, wrapping upward.
    // Scanning from the far end lets the closest requester win last.
    always_comb begin
        rr_pick_s = rr_ptr_q;
        for (int unsigned off = NUM_MGR; off > 32'd0; off--) begin
            if (bus.m_obi_req[wrap_add(rr_ptr_q, off - 32'd1)]) begin
                rr_pick_s = wrap_add(rr_ptr_q, off - 32'd1);
            end else begin
                rr_pick_s = rr_pick_s;
            end
        end
    end

    // Selected manager: the held index while a presented request awaits gnt.
    always_comb begin
        case (state_q)
            ARB_HOLD: sel_s = hold_idx_q;
            ARB_IDLE: sel_s = rr_pick_s;
            default:  sel_s = rr_pick_s;
        endcase
    end

    // Address path: new requests are blocked while every FIFO slot is in use.
    assign s_req_s          = bus.m_obi_req[sel_s] & ~fifo_full_s;
    assign addr_hs_s        = s_req_s & bus.s_obi_gnt;
    assign bus.s_obi_req    = s_req_s;
    assign bus.s_obi_addr   = bus.m_obi_addr[sel_s*ADDR_W +: ADDR_W];
    assign bus.s_obi_we     = bus.m_obi_we[sel_s];
    assign bus.s_obi_be     = bus.m_obi_be[sel_s*BE_W +: BE_W];
    assign bus.s_obi_wdata  = bus.m_obi_wdata[sel_s*DATA_W +: DATA_W];
    assign bus.s_obi_aid    = bus.m_obi_aid[sel_s*ID_W +: ID_W];

    // One-hot grant to the selected manager on an address handshake.
    always_comb begin
        gnt_s        = '0;
        gnt_s[sel_s] = addr_hs_s;
    end
    assign bus.m_obi_gnt = gnt_s;

    // One-hot rvalid to the manager at the FIFO head.
    always_comb begin
        rvalid_s              = '0;
        rvalid_s[fifo_head_s] = bus.s_obi_rvalid & ~fifo_empty_s;
    end
    assign bus.m_obi_rvalid = rvalid_s;

    // Response path: with nothing outstanding, stray responses are drained.
    assign bus.s_obi_rready = bus.m_obi_rready[fifo_head_s] | fifo_empty_s;
    assign fifo_pop_s       = bus.s_obi_rvalid & bus.s_obi_rready & ~fifo_empty_s;
    assign bus.m_obi_rdata  = bus.s_obi_rdata;
    assign bus.m_obi_err    = bus.s_obi_err;
    assign bus.m_obi_rid    = bus.s_obi_rid;
    assign resp_orphan      = resp_orphan_q;

    obi_arb_idx_fifo #(
        .DEPTH (MAX_OUT),
        .W     (IDX_W)
    ) u_idx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (addr_hs_s),
        .pop_i   (fifo_pop_s),
        .din_i   (sel_s),
        .head_o  (fifo_head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (unused_fifo_count_s)
    );

    // Arbiter FSM: hold an ungranted selection, advance rr_ptr past each granted manager.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            hold_idx_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            // A withdrawn held request also returns to IDLE so others are not starved.
            if (s_req_s && !bus.s_obi_gnt) begin
                state_q    <= ARB_HOLD;
                hold_idx_q <= sel_s;
            end else begin
                state_q    <= ARB_IDLE;
            end
            if (addr_hs_s) begin
                rr_ptr_q <= wrap_add(sel_s, 32'd1);
            end
        end
    end

    // Sticky flag: a response arrived while nothing was outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_orphan_q <= 1'b0;
        end else if (bus.s_obi_rvalid && fifo_empty_s) begin
            resp_orphan_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_obi_arbiter.sv
// Randomized bench for obi_arbiter: managers and subordinate are modelled
// here, a reference model tracks outstanding transactions as a queue of
// manager indices, and a monitor checks routed responses against a queue of
// expected responses.
module tb_obi_arbiter;
    import obi_arb_pkg::*;

    localparam int NUM_MGR = 2;
    localparam int MAX_OUT = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int ID_W    = 1;
    localparam int BE_W    = DATA_W / 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic resp_orphan;

    always #5 clk = ~clk;

    obi_arbiter_if #(.NUM_MGR(NUM_MGR), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

    obi_arbiter #(
        .NUM_MGR (NUM_MGR),
        .MAX_OUT (MAX_OUT),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .ID_W    (ID_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .resp_orphan (resp_orphan)
    );

    typedef struct {
        int                mgr;
        logic [DATA_W-1:0] rdata;
        logic              err;
        logic [ID_W-1:0]   rid;
    } resp_t;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int    rr = 0;
    int    held = -1;
    int    outst[$];
    resp_t sub_q[$];
    resp_t exp_q[$];
    bit    sub_busy = 1'b0;
    bit    orphan_exp = 1'b0;
    int    txn_cnt = 0;

    // manager state
    bit                active [NUM_MGR];
    logic [ADDR_W-1:0] a_addr [NUM_MGR];
    logic              a_we   [NUM_MGR];
    logic [BE_W-1:0]   a_be   [NUM_MGR];
    logic [DATA_W-1:0] a_wdata[NUM_MGR];
    logic [ID_W-1:0]   a_aid  [NUM_MGR];

    logic [NUM_MGR-1:0] mon_ev;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic apply_mgrs();
        for (int i = 0; i < NUM_MGR; i++) begin
            bus.m_obi_req[i]                     = active[i];
            bus.m_obi_addr[i*ADDR_W +: ADDR_W]   = a_addr[i];
            bus.m_obi_we[i]                      = a_we[i];
            bus.m_obi_be[i*BE_W +: BE_W]         = a_be[i];
            bus.m_obi_wdata[i*DATA_W +: DATA_W]  = a_wdata[i];
            bus.m_obi_aid[i*ID_W +: ID_W]        = a_aid[i];
        end
    endtask

    task automatic new_req(input int i, input logic [ADDR_W-1:0] addr, input logic we);
        active[i]  = 1'b1;
        a_addr[i]  = addr;
        a_we[i]    = we;
        a_be[i]    = BE_W'($urandom);
        a_wdata[i] = DATA_W'($urandom);
        a_aid[i]   = ID_W'($urandom);
    endtask

    // Subordinate: present the oldest accepted transaction's response.
    task automatic drive_sub(input int rv_pct);
        if (!sub_busy && sub_q.size() > 0 && int'($urandom_range(99)) < rv_pct) begin
            sub_busy = 1'b1;
            exp_q.push_back(sub_q[0]);
        end
        bus.s_obi_rvalid = sub_busy;
        if (sub_busy) begin
            bus.s_obi_rdata = sub_q[0].rdata;
            bus.s_obi_err   = sub_q[0].err;
            bus.s_obi_rid   = sub_q[0].rid;
        end else begin
            bus.s_obi_rdata = DATA_W'($urandom);
            bus.s_obi_err   = 1'($urandom);
            bus.s_obi_rid   = ID_W'($urandom);
        end
    endtask

    task automatic drive_rand(input int gnt_pct, input int rv_pct, input int new_pct);
        for (int i = 0; i < NUM_MGR; i++) begin
            if (!active[i] && int'($urandom_range(99)) < new_pct) begin
                new_req(i, ADDR_W'($urandom), 1'($urandom));
            end
            bus.m_obi_rready[i] = (int'($urandom_range(99)) < 70);
        end
        apply_mgrs();
        bus.s_obi_gnt = (int'($urandom_range(99)) < gnt_pct);
        drive_sub(rv_pct);
    endtask

    // One cycle: compare at negedge against the model, then advance the model.
    task automatic step();
        int                 sel;
        bit                 sreq;
        bit                 exp_rr;
        logic [NUM_MGR-1:0] exp_gnt;
        resp_t              r;
        @(negedge clk);
        sel = -1;
        if (held >= 0) begin
            sel = held;
        end else begin
            for (int k = 0; k < NUM_MGR; k++) begin
                if (active[(rr + k) % NUM_MGR]) begin
                    sel = (rr + k) % NUM_MGR;
                    break;
                end
            end
        end
        sreq = (sel >= 0) && active[sel] && (outst.size() < MAX_OUT);
        exp_gnt = '0;
        if (sreq && bus.s_obi_gnt) exp_gnt[sel] = 1'b1;
        chk("s_obi_req", 64'(bus.s_obi_req), 64'(sreq));
        chk("m_obi_gnt", 64'(bus.m_obi_gnt), 64'(exp_gnt));
        if (sreq) begin
            chk("s_obi_addr",  64'(bus.s_obi_addr),  64'(a_addr[sel]));
            chk("s_obi_we",    64'(bus.s_obi_we),    64'(a_we[sel]));
            chk("s_obi_be",    64'(bus.s_obi_be),    64'(a_be[sel]));
            chk("s_obi_wdata", 64'(bus.s_obi_wdata), 64'(a_wdata[sel]));
            chk("s_obi_aid",   64'(bus.s_obi_aid),   64'(a_aid[sel]));
        end
        exp_rr = (outst.size() == 0) ? 1'b1 : bus.m_obi_rready[outst[0]];
        chk("s_obi_rready", 64'(bus.s_obi_rready), 64'(exp_rr));
        chk("resp_orphan", 64'(resp_orphan), 64'(orphan_exp));
        // response handshake
        if (bus.s_obi_rvalid && exp_rr) begin
            if (outst.size() > 0) void'(outst.pop_front());
            else orphan_exp = 1'b1;
            if (sub_busy) begin
                sub_busy = 1'b0;
                void'(sub_q.pop_front());
            end
        end
        // address handshake
        if (sreq && bus.s_obi_gnt) begin
            outst.push_back(sel);
            rr        = (sel + 1) % NUM_MGR;
            held      = -1;
            active[sel] = 1'b0;
            r.mgr   = sel;
            r.rdata = (txn_cnt == 0) ? 32'hDEADBEEF : DATA_W'($urandom);
            r.err   = 1'($urandom);
            r.rid   = a_aid[sel];
            sub_q.push_back(r);
            txn_cnt++;
        end else if (sreq) begin
            held = sel;
        end else begin
            held = -1;
        end
        @(posedge clk);
        #1;
    endtask

    // Response monitor: whatever the subordinate presents must reach exactly the
    // manager at the head of the expected queue, with data passed through.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.s_obi_rvalid && exp_q.size() > 0) begin
                mon_ev = '0;
                mon_ev[exp_q[0].mgr] = 1'b1;
                chk("m_obi_rvalid", 64'(bus.m_obi_rvalid), 64'(mon_ev));
                chk("m_obi_rdata",  64'(bus.m_obi_rdata),  64'(exp_q[0].rdata));
                chk("m_obi_err",    64'(bus.m_obi_err),    64'(exp_q[0].err));
                chk("m_obi_rid",    64'(bus.m_obi_rid),    64'(exp_q[0].rid));
                if (bus.m_obi_rready[exp_q[0].mgr]) void'(exp_q.pop_front());
            end else begin
                chk("m_obi_rvalid_idle", 64'(bus.m_obi_rvalid), 64'(0));
            end
        end
    end

    task automatic clear_model();
        outst.delete();
        sub_q.delete();
        exp_q.delete();
        held = -1;
        rr = 0;
        sub_busy = 1'b0;
        orphan_exp = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NUM_MGR; i++) begin
            active[i] = 1'b0; a_addr[i] = '0; a_we[i] = 1'b0;
            a_be[i] = '0; a_wdata[i] = '0; a_aid[i] = '0;
        end
        apply_mgrs();
        bus.m_obi_rready = '0;
        bus.s_obi_gnt = 1'b0;
        drive_sub(0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        step();                        // reset state
        rst_n = 1'b1;
        step();

        // single read: m0 reads 0x100, granted at once, response two cycles later
        new_req(0, 32'h0000_0100, 1'b0);
        apply_mgrs();
        bus.s_obi_gnt = 1'b1;
        step();
        apply_mgrs();
        bus.s_obi_gnt = 1'b0;
        step();
        bus.m_obi_rready = '1;
        drive_sub(100);
        step();
        bus.m_obi_rready = '0;
        drive_sub(0);
        step();                        // FIFO empty again: s_obi_rready=1

        // random phases: free-flowing, stalling subordinate, slow responses (full FIFO)
        for (int c = 0; c < 300; c++) begin drive_rand(100, 60, 90); step(); end
        for (int c = 0; c < 300; c++) begin drive_rand(40, 50, 70);  step(); end
        for (int c = 0; c < 250; c++) begin drive_rand(90, 8, 90);   step(); end
        for (int c = 0; c < 80; c++)  begin drive_rand(0, 100, 0);   step(); end

        // reset with transactions outstanding, then a late response is an orphan
        for (int c = 0; c < 20 && outst.size() < 2; c++) begin drive_rand(100, 0, 100); step(); end
        if (outst.size() < 2) begin
            n_checks++;
            n_fail++;
            $display("FAIL orphan_setup: got %0d outstanding expected at least 2", outst.size());
        end
        for (int i = 0; i < NUM_MGR; i++) active[i] = 1'b0;
        apply_mgrs();
        bus.s_obi_gnt = 1'b0;
        bus.m_obi_rready = '0;
        clear_model();
        drive_sub(0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        bus.s_obi_rvalid = 1'b1;
        bus.s_obi_rdata  = 32'h1234_5678;
        step();
        bus.s_obi_rvalid = 1'b0;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
